display_mux_gen: RTL and testbench
==================================

Name: display_mux_gen

Overview:
Parametrised, time-multiplexed seven-segment display driver for 1 to 8 digits. It adds several features to a plain refresh mux: per-digit enable, per-digit blink, global PWM brightness, an inter-digit ghosting guard, and tear-free double-buffered updates committed at frame boundaries. It sits between the display-formatting logic (hex/BCD-to-segment encoders) and the board's active-low anode/segment pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..8).
DIV_W, 16, prescaler width; slot length = 2^DIV_W clk cycles.
BRIGHT_W, 4, brightness code width; requires BRIGHT_W <= DIV_W.
GUARD, 4, cycles at slot start with all anodes off (anti-ghosting); requires GUARD < 2^(DIV_W-BRIGHT_W).
BLINK_W, 5, frame counter width; blink phase = counter MSB.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
segs_in  in  8*NUM_DIGITS  digit i pattern at [8i+7:8i], {dp,g,f,e,d,c,b,a}, active-low
digit_en  in  NUM_DIGITS  1 = digit displayed
blink_en  in  NUM_DIGITS  1 = digit blanked during blink phase
brightness  in  BRIGHT_W  duty code; 0 = dark
update_req  in  1  single-cycle pulse: commit inputs to shadow registers
update_ack  out  1  single-cycle pulse when the commit occurs
frame_start  out  1  single-cycle pulse at start of slot 0
an  out  8  active-low digit enables; digit i drives an[i]; an[7:NUM_DIGITS] always 1
sseg  out  8  active-low segment bus

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low: reset_n is sampled on the rising edge of clk.
- Reset (reset_n = 0 at an edge) clears the following: prescaler, slot, blink counter, pending flag, all shadow registers (digit_en = 0, brightness = 0). Outputs after that edge: an = 8'hFF, sseg = 8'hFF, update_ack = 0, frame_start = 0. Reset mid-frame behaves the same way; the frame restarts at slot 0.
- Prescaler presc: DIV_W bits, increments every cycle and wraps to 0. On wrap, slot advances 0..NUM_DIGITS-1 and wraps to 0.
- A frame ends when the slot wraps. At each frame end the blink counter increments, wrapping modulo 2^BLINK_W.
- pwm_phase = presc[DIV_W-1 -: BRIGHT_W].
- Digit s is lit when all of the following hold: shadow digit_en[s] = 1; presc >= GUARD; pwm_phase < shadow brightness; and NOT (blink_en[s] AND blink counter MSB).
- Lit: an = ~(8'b1 << s), sseg = shadow segs[s]. Otherwise: an = 8'hFF, sseg = 8'hFF.
- an and sseg are registered, giving 1-cycle latency from the (slot, presc) state to the pins.
- Disabled or blanked digits still consume their full slot, so refresh rate is independent of enables.
- update_req sets the pending flag. At the next cycle where slot = 0 and presc = 0 with pending set, the shadow registers load from the live inputs, pending clears, and update_ack pulses that same cycle.
- update_req coincident with slot = 0, presc = 0: the commit happens that cycle.
- update_req while already pending: no extra effect (one ack).
- update_req coincident with a commit: the commit takes that cycle's inputs; pending is left clear.
- frame_start = 1 exactly when slot = 0 and presc = 0 (combinational from state).
- Width rules: the slot counter is $clog2(NUM_DIGITS) bits, minimum 1; compare against NUM_DIGITS-1 for the wrap (NUM_DIGITS need not be a power of 2).

Decomposition:
- Package display_pkg: SEG_OFF = 8'hFF, AN_OFF = 8'hFF, a seg_t typedef (logic [7:0]), and the digit-to-anode decode function.
- One sub-module: display_pwm_timer. It holds the prescaler, slot, and blink counters, and produces slot, presc, frame_start, and blink_phase.
- The top module holds the shadow registers, the commit handshake, and the output register stage.

Test Plan:
All scenarios use NUM_DIGITS=4, DIV_W=4, BRIGHT_W=2, GUARD=1, BLINK_W=2 (slot = 16 cycles, frame = 64 cycles).
1. reset_n=0 for 3 edges -> an=8'hFF, sseg=8'hFF, update_ack=0, frame_start=0. Asserting reset_n=0 mid-frame returns the same values after the next edge.
2. segs_in={8'hA4,8'hB0,8'hF9,8'hC0}, digit_en=4'hF, brightness=3, update_req pulse -> update_ack at the next frame_start. Then, in slot 0, an=8'hFE with sseg=8'hC0 for exactly 11 cycles (presc 1..11, +1 cycle latency). Slots 1..3 follow with an=FD/FB/F7.
3. brightness=1 -> each digit lit 3 cycles per slot (presc 1..3). brightness=0 -> an stays 8'hFF for a full frame.
4. digit_en=4'b0101 -> an[1] and an[3] never low; slots still 16 cycles each; frame_start period = 64 cycles.
5. blink_en=4'b0100 -> digit 2 lit in frames with counter 0,1 and dark in frames 2,3; other digits unaffected.
6. update_req mid-frame with new segs_in -> pins keep old patterns until the next frame_start, then show the new ones. A second update_req while pending -> exactly one update_ack.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types, idle pin levels and the slot-to-anode decode for the seven-segment display driver.
package display_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t       SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  function automatic logic [7:0] an_decode(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/display_pwm_timer.sv
// Refresh timebase: prescaler, digit slot and frame (blink) counters for the display mux.
module display_pwm_timer #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_W      = 16,
  parameter int BLINK_W    = 5,
  localparam int SLOT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [SLOT_W-1:0] slot,
  output logic [DIV_W-1:0]  presc,
  output logic              frame_start,
  output logic              blink_phase
);

  logic [BLINK_W-1:0] blink;
  logic               presc_last;
  logic               slot_last;

  assign presc_last = &presc;
  assign slot_last  = (slot == SLOT_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc <= '0;
      slot  <= '0;
      blink <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (presc_last) begin
        if (slot_last) begin
          slot  <= '0;
          blink <= blink + 1'b1;
        end else begin
          slot <= slot + 1'b1;
        end
      end
    end
  end

  // Held low while reset is asserted so no commit can fire during reset.
  assign frame_start = reset_n && (slot == '0) && (presc == '0);
  assign blink_phase = blink[BLINK_W-1];

endmodule

// File: rtl/display_mux_gen.sv
// Time-multiplexed seven-segment driver with per-digit enable/blink, PWM brightness and frame-aligned double buffering.
module display_mux_gen
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_W      = 16,
  parameter int BRIGHT_W   = 4,
  parameter int GUARD      = 4,
  parameter int BLINK_W    = 5,
  localparam int SLOT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8*NUM_DIGITS-1:0] segs_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    update_req,
  output logic                    update_ack,
  output logic                    frame_start,
  output logic [7:0]              an,
  output logic [7:0]              sseg
);

  logic [SLOT_W-1:0]   slot;
  logic [DIV_W-1:0]    presc;
  logic                blink_phase;
  logic [BRIGHT_W-1:0] pwm_phase;

  seg_t                sh_segs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sh_en;
  logic [BRIGHT_W-1:0] sh_bright;
  logic                pending;
  logic                commit;

  logic                lit_p0;
  logic [7:0]          an_p0;
  seg_t                sseg_p0;

  display_pwm_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIV_W      (DIV_W),
    .BLINK_W    (BLINK_W)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .slot        (slot),
    .presc       (presc),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  // A request arriving on the commit cycle is absorbed by that commit.
  assign commit     = frame_start && (pending || update_req);
  assign update_ack = commit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending   <= 1'b0;
      sh_en     <= '0;
      sh_bright <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) sh_segs[i] <= SEG_OFF;
    end else if (commit) begin
      pending   <= 1'b0;
      sh_en     <= digit_en;
      sh_bright <= brightness;
      for (int i = 0; i < NUM_DIGITS; i++) sh_segs[i] <= segs_in[8*i +: 8];
    end else if (update_req) begin
      pending <= 1'b1;
    end
  end

  // Stage p0: lit decision from current (slot, presc) state
  assign pwm_phase = presc[DIV_W-1 -: BRIGHT_W];
  assign lit_p0    = sh_en[slot] && (presc >= DIV_W'(GUARD)) && (pwm_phase < sh_bright)
                     && !(blink_en[slot] && blink_phase);
  assign an_p0     = lit_p0 ? an_decode(3'(slot)) : AN_OFF;
  assign sseg_p0   = lit_p0 ? sh_segs[slot] : SEG_OFF;

  // Stage p1: registered pins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an   <= AN_OFF;
      sseg <= SEG_OFF;
    end else begin
      an   <= an_p0;
      sseg <= sseg_p0;
    end
  end

endmodule

// File: tb/tb_display_mux_gen.sv
// Bench for display_mux_gen: directed scenarios plus random traffic against a time-indexed behavioural model.
module tb_display_mux_gen;

  localparam int ND = 4, DW = 4, BW = 2, GD = 1, KW = 2;
  localparam int SLOT_LEN = 1 << DW;
  localparam int FRAME_LEN = SLOT_LEN * ND;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] segs_in = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  blink_en = '0;
  logic [1:0]  brightness = '0;
  logic        update_req = 1'b0;
  logic        update_ack;
  logic        frame_start;
  logic [7:0]  an;
  logic [7:0]  sseg;

  display_mux_gen #(
    .NUM_DIGITS (ND),
    .DIV_W      (DW),
    .BRIGHT_W   (BW),
    .GUARD      (GD),
    .BLINK_W    (KW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .segs_in     (segs_in),
    .digit_en    (digit_en),
    .blink_en    (blink_en),
    .brightness  (brightness),
    .update_req  (update_req),
    .update_ack  (update_ack),
    .frame_start (frame_start),
    .an          (an),
    .sseg        (sseg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: elapsed cycles since reset release plus shadow copy of the last committed inputs
  int         t = 0;
  bit         pend = 1'b0;
  logic [7:0] m_seg [4];
  logic [3:0] m_en = '0;
  logic [1:0] m_br = '0;

  int cnt_fs, cnt_ack, cnt_fe, cnt_lit, cnt_bad13;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s t=%0d got %h expected %h", tag, t, got, exp);
    end
  endtask

  task automatic clr_counts();
    cnt_fs = 0; cnt_ack = 0; cnt_fe = 0; cnt_lit = 0; cnt_bad13 = 0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered pins.
  task automatic step();
    logic [7:0] e_an, e_seg;
    logic       e_fs, e_ack;
    int         s, p;
    #1;
    e_an = 8'hFF; e_seg = 8'hFF; e_fs = 1'b0; e_ack = 1'b0;
    if (reset_n) begin
      s = (t / SLOT_LEN) % ND;
      p = t % SLOT_LEN;
      e_fs  = (t % FRAME_LEN == 0);
      e_ack = e_fs && (pend || update_req);
      if (m_en[s] && p >= GD && (p / (1 << (DW - BW))) < m_br &&
          !(blink_en[s] && ((t / FRAME_LEN) % (1 << KW)) >= (1 << (KW - 1)))) begin
        e_an  = ~(8'h01 << s);
        e_seg = m_seg[s];
      end
    end
    chk("frame_start", {7'b0, frame_start}, {7'b0, e_fs});
    chk("update_ack", {7'b0, update_ack}, {7'b0, e_ack});
    cnt_fs  += int'(frame_start);
    cnt_ack += int'(update_ack);
    if (!reset_n) begin
      t = 0; pend = 1'b0; m_en = '0; m_br = '0;
      for (int i = 0; i < 4; i++) m_seg[i] = 8'hFF;
    end else begin
      if (e_ack) begin
        m_en = digit_en; m_br = brightness; pend = 1'b0;
        for (int i = 0; i < 4; i++) m_seg[i] = segs_in[8*i +: 8];
      end else if (update_req) begin
        pend = 1'b1;
      end
      t++;
    end
    @(posedge clk);
    #1;
    chk("an", an, e_an);
    chk("sseg", sseg, e_seg);
    if (an == 8'hFE) cnt_fe++;
    if (an != 8'hFF) cnt_lit++;
    if (!an[1] || !an[3]) cnt_bad13++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_frame();
    for (int i = 0; i < FRAME_LEN && (t % FRAME_LEN) != 0; i++) step();
  endtask

  task automatic pulse_req();
    update_req = 1'b1;
    step();
    update_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_seg[i] = 8'hFF;
    clr_counts();
    @(negedge clk);

    // Reset held three edges
    run(3);
    reset_n = 1'b1;

    // Basic commit and full-brightness frame
    segs_in = {8'hA4, 8'hB0, 8'hF9, 8'hC0};
    digit_en = 4'hF;
    brightness = 2'd3;
    run(5);
    clr_counts();
    pulse_req();
    run_to_frame();
    run(1);
    chk("ack_wait_first", 8'(cnt_ack), 8'd1);
    run(FRAME_LEN - 1);
    chk("slot0_lit_cycles", 8'(cnt_fe), 8'd11);

    // Brightness 1, then 0
    brightness = 2'd1;
    pulse_req();
    run_to_frame();
    clr_counts();
    run(FRAME_LEN);
    chk("bright1_lit", 8'(cnt_lit), 8'd12);
    brightness = 2'd0;
    pulse_req();
    run_to_frame();
    clr_counts();
    run(FRAME_LEN);
    chk("bright0_lit", 8'(cnt_lit), 8'd0);

    // Sparse enables
    brightness = 2'd3;
    digit_en = 4'b0101;
    pulse_req();
    run_to_frame();
    clr_counts();
    run(2 * FRAME_LEN);
    chk("en_odd_dark", 8'(cnt_bad13), 8'd0);
    chk("frame_period", 8'(cnt_fs), 8'd2);

    // Blink on digit 2 over all four blink frames
    digit_en = 4'hF;
    blink_en = 4'b0100;
    pulse_req();
    run_to_frame();
    run(4 * FRAME_LEN);
    blink_en = 4'b0000;

    // Mid-frame update with a second request while pending
    run(10);
    clr_counts();
    segs_in = {8'h99, 8'h92, 8'h82, 8'hF8};
    pulse_req();
    run(5);
    pulse_req();
    run_to_frame();
    run(FRAME_LEN);
    chk("double_req_one_ack", 8'(cnt_ack), 8'd1);

    // Reset mid-frame
    run(20);
    reset_n = 1'b0;
    run(1);
    reset_n = 1'b1;
    run(FRAME_LEN);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      segs_in    = $urandom;
      digit_en   = 4'($urandom);
      blink_en   = 4'($urandom);
      brightness = 2'($urandom);
      update_req = ($urandom_range(0, 15) == 0);
      reset_n    = ($urandom_range(0, 599) != 0);
      step();
    end
    update_req = 1'b0;
    reset_n = 1'b1;
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
